gpo_cmd_master: RTL and testbench

Hardware initiator for the GPO/GPI command protocol that the register file decodes. It accepts command requests from on-chip logic, such as a sweep sequencer or a BER polling engine, in place of the microprocessor. For each request it drives the 32-bit GPO word, generating a clean enable rising edge. It then samples the GPI response word after a programmable settle time. Wide (64-bit) reads automatically issue the high-half command and return both halves together.

---
 rtl/gpo_cmd_master.sv | 138 +++++++++++++
 tb/tb_gpo_cmd_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_cmd_master.sv
// gpo_cmd_master: on-chip initiator for the GPO/GPI command protocol.
// Drives clean enable pulses and collects 32- or 64-bit GPI responses.
module gpo_cmd_master #(
  parameter int          HOLD_CYCLES = 2,
  parameter int          RSP_WAIT    = 3,
  parameter logic [7:0]  CMD_HIGH    = 8'd11
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [7:0]  i_req_cmd,
  input  logic [22:0] i_req_data,
  input  logic        i_req_wide,
  output logic [31:0] o_gpo,
  input  logic [31:0] i_gpi,
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_data,
  output logic        o_busy
);

  localparam int MAXC = (HOLD_CYCLES > RSP_WAIT) ? HOLD_CYCLES : RSP_WAIT;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [22:0]   data_q, data_d;
  logic          en_q, en_d;
  logic          wide_q, wide_d;
  logic          phase_q, phase_d;
  logic [63:0]   rsp_q, rsp_d;
  logic          vld_q, vld_d;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      wide_q  <= 1'b0;
      phase_q <= 1'b0;
      rsp_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      en_q    <= en_d;
      wide_q  <= wide_d;
      phase_q <= phase_d;
      rsp_q   <= rsp_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    en_d    = 1'b0;
    wide_d  = wide_q;
    phase_d = phase_q;
    rsp_d   = rsp_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          state_d = S_SETUP;
          cmd_d   = i_req_cmd;
          data_d  = i_req_data;
          wide_d  = i_req_wide;
          phase_d = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_ASSERT;
        en_d    = 1'b1;
        cnt_d   = CW'(HOLD_CYCLES - 1);
      end
      S_ASSERT: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = CW'(RSP_WAIT - 1);
        end else begin
          en_d  = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!phase_q) begin
          rsp_d[31:0] = i_gpi;
          if (wide_q) begin
            // reissue as the high-half command; enable edge comes fresh
            phase_d = 1'b1;
            cmd_d   = CMD_HIGH;
            data_d  = '0;
            state_d = S_SETUP;
          end else begin
            rsp_d[63:32] = '0;
            state_d      = S_RESP;
            vld_d        = 1'b1;
          end
        end else begin
          rsp_d[63:32] = i_gpi;
          state_d      = S_RESP;
          vld_d        = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign o_gpo       = {cmd_q, en_q, data_q};
  assign o_req_ready = (state_q == S_IDLE);
  assign o_busy      = ~o_req_ready;
  assign o_rsp_valid = vld_q;
  assign o_rsp_data  = rsp_q;

endmodule

// File: tb/tb_gpo_cmd_master.sv
// tb_gpo_cmd_master: checks default and minimum-parameter instances
// against a timeline model derived from edge counts after acceptance.
module tb_gpo_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        valid [2];
  logic [7:0]  cmd [2];
  logic [22:0] data [2];
  logic        wide [2];
  logic [31:0] gpi [2];
  logic        ready [2];
  logic [31:0] gpo [2];
  logic        rsp_valid [2];
  logic [63:0] rsp_data [2];
  logic        busy [2];

  int checks = 0;
  int errors = 0;

  int hp [2] = '{2, 1};
  int wp [2] = '{3, 1};

  gpo_cmd_master #(
    .HOLD_CYCLES(2), .RSP_WAIT(3), .CMD_HIGH(8'd11)
  ) dut0 (
    .clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid[0]), .o_req_ready(ready[0]),
    .i_req_cmd(cmd[0]), .i_req_data(data[0]),
    .i_req_wide(wide[0]), .o_gpo(gpo[0]), .i_gpi(gpi[0]),
    .o_rsp_valid(rsp_valid[0]), .o_rsp_data(rsp_data[0]),
    .o_busy(busy[0])
  );

  gpo_cmd_master #(
    .HOLD_CYCLES(1), .RSP_WAIT(1), .CMD_HIGH(8'd11)
  ) dut1 (
    .clk(clk), .i_rst_n(rst_n),
    .i_req_valid(valid[1]), .o_req_ready(ready[1]),
    .i_req_cmd(cmd[1]), .i_req_data(data[1]),
    .i_req_wide(wide[1]), .o_gpo(gpo[1]), .i_gpi(gpi[1]),
    .o_rsp_valid(rsp_valid[1]), .o_rsp_data(rsp_data[1]),
    .o_busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: k = edges since acceptance, one phase = H+W+1 edges
  logic        act [2];
  int          k [2];
  logic        lwide [2];
  logic [7:0]  gcmd [2];
  logic [22:0] gdata [2];
  logic [63:0] rsp [2];
  int          mp;

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      mp = hp[i] + wp[i] + 1;
      if (!rst_n) begin
        act[i] = 1'b0; k[i] = 0; lwide[i] = 1'b0;
        gcmd[i] = '0; gdata[i] = '0; rsp[i] = '0;
      end else if (!act[i]) begin
        if (valid[i]) begin
          act[i] = 1'b1; k[i] = 0; lwide[i] = wide[i];
          gcmd[i] = cmd[i]; gdata[i] = data[i];
        end
      end else begin
        k[i] = k[i] + 1;
        if (k[i] == mp) begin
          rsp[i][31:0] = gpi[i];
          if (lwide[i]) begin
            gcmd[i] = 8'd11; gdata[i] = '0;
          end else begin
            rsp[i][63:32] = '0;
          end
        end else if (lwide[i] && k[i] == 2 * mp) begin
          rsp[i][63:32] = gpi[i];
        end
        if (k[i] > (lwide[i] ? 2 * mp : mp)) act[i] = 1'b0;
      end
    end
  end

  function automatic int p_of(int i);
    return hp[i] + wp[i] + 1;
  endfunction

  function automatic int end_of(int i);
    return lwide[i] ? 2 * p_of(i) : p_of(i);
  endfunction

  function automatic logic en_exp(int i);
    int o;
    if (!act[i] || k[i] >= end_of(i)) return 1'b0;
    o = k[i] % p_of(i);
    return (o >= 1 && o <= hp[i]);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("gpo%0d", i), 64'(gpo[i]),
          64'({gcmd[i], en_exp(i), gdata[i]}));
      chk($sformatf("rsp_valid%0d", i), 64'(rsp_valid[i]),
          64'(act[i] && k[i] == end_of(i)));
      chk($sformatf("rsp_data%0d", i), rsp_data[i], rsp[i]);
      chk($sformatf("ready%0d", i), 64'(ready[i]), 64'(!act[i]));
      chk($sformatf("busy%0d", i), 64'(busy[i]), 64'(act[i]));
    end
  endtask

  // enable-edge monitor
  logic pen [2] = '{1'b0, 1'b0};
  logic seen [2] = '{1'b0, 1'b0};
  int   low [2] = '{0, 0};
  int   rises [2] = '{0, 0};

  task automatic monitor();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        seen[i] = 1'b0; low[i] = 0;
      end else if (gpo[i][23] && !pen[i]) begin
        rises[i]++;
        if (seen[i])
          chk($sformatf("en_gap%0d", i),
              64'(low[i] >= wp[i] + 1), 64'd1);
        seen[i] = 1'b1; low[i] = 0;
      end else if (!gpo[i][23]) begin
        low[i]++;
      end
      pen[i] = gpo[i][23];
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    monitor();
  endtask

  task automatic drive(logic v, logic [7:0] c, logic [22:0] d, logic w);
    for (int i = 0; i < 2; i++) begin
      valid[i] = v; cmd[i] = c; data[i] = d; wide[i] = w;
    end
  endtask

  task automatic set_gpi_phased();
    for (int i = 0; i < 2; i++)
      gpi[i] = (act[i] && k[i] >= p_of(i)) ? 32'h0000_0012
                                            : 32'hDEAD_BEEF;
  endtask

  int lat [2];
  logic seen_hi;

  task automatic run_txn(logic [7:0] c, logic [22:0] d, logic w);
    lat[0] = -1; lat[1] = -1; seen_hi = 1'b0;
    drive(1'b1, c, d, w);
    set_gpi_phased();
    step();
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      set_gpi_phased();
      step();
      for (int i = 0; i < 2; i++)
        if (rsp_valid[i] && lat[i] < 0) lat[i] = n;
      if (gpo[0][31:24] == 8'h0B && gpo[0][23]) seen_hi = 1'b1;
    end
  endtask

  int r0;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    gpi[0] = '0; gpi[1] = '0;
    #1;
    chk("reset_gpo", 64'(gpo[0]), 64'h0);
    chk("reset_ready", 64'(ready[0]), 64'h1);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    step();

    // narrow write, cmd 1 data 1
    run_txn(8'd1, 23'd1, 1'b0);
    chk("narrow_lat0", 64'(lat[0]), 64'd6);
    chk("narrow_lat1", 64'(lat[1]), 64'd3);
    chk("narrow_rsp0", rsp_data[0], 64'h0000_0000_DEAD_BEEF);

    // wide read, cmd 7
    run_txn(8'd7, 23'h00_0005, 1'b1);
    chk("wide_lat0", 64'(lat[0]), 64'd12);
    chk("wide_lat1", 64'(lat[1]), 64'd6);
    chk("wide_rsp0", rsp_data[0], 64'h0000_0012_DEAD_BEEF);
    chk("wide_rsp1", rsp_data[1], 64'h0000_0012_DEAD_BEEF);
    chk("wide_cmd_high", 64'(seen_hi), 64'd1);

    // back-to-back with valid held high
    r0 = rises[0];
    drive(1'b1, 8'd3, 23'h12345, 1'b0);
    for (int n = 0; n < 20; n++) begin
      gpi[0] = $urandom; gpi[1] = $urandom;
      step();
    end
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    for (int n = 0; n < 10; n++) step();
    chk("b2b_rises0", 64'(rises[0] - r0 >= 2), 64'd1);

    // request pulsed while busy is ignored
    r0 = rises[0];
    drive(1'b1, 8'd1, 23'h1, 1'b0);
    step();
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    step();
    step();
    drive(1'b1, 8'd2, 23'h2, 1'b0);
    step();
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    for (int n = 0; n < 10; n++) step();
    chk("busy_rises0", 64'(rises[0] - r0), 64'd1);
    chk("busy_cmd0", 64'(gpo[0][31:24]), 64'd1);

    // asynchronous reset during ASSERT
    drive(1'b1, 8'd4, 23'h7, 1'b0);
    step();
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    step();
    chk("pre_rst_en0", 64'(gpo[0][23]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gpo0", 64'(gpo[0]), 64'h0);
    chk("async_vld0", 64'(rsp_valid[0]), 64'h0);
    check_all();
    step();
    rst_n = 1'b1;
    step();
    run_txn(8'd5, 23'h4_0001, 1'b0);
    chk("post_rst_lat0", 64'(lat[0]), 64'd6);
    chk("post_rst_lat1", 64'(lat[1]), 64'd3);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(0, 2) == 0);
        cmd[i]   = 8'($urandom);
        data[i]  = 23'($urandom);
        wide[i]  = 1'($urandom);
        gpi[i]   = $urandom;
      end
      step();
    end
    drive(1'b0, 8'h00, 23'h0, 1'b0);
    for (int n = 0; n < 30; n++) step();
    chk("final_idle0", 64'(ready[0]), 64'd1);
    chk("final_idle1", 64'(ready[1]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
